// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One multiplier or quotient bit per cycle: 32 iterations plus a write-back cycle.
module hilo_muldiv #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Hilo_en,
  input  logic [5:0]      Function_opcode,
  input  logic [XLEN-1:0] Read_data_1,
  input  logic [XLEN-1:0] Read_data_2,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            Busy,
  output logic            Done
);

  localparam int CW = $clog2(ITER + 1);

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   counter;
  logic [2*XLEN-1:0] acc;        // mul: {partial product, multiplier}; div: low half is quotient
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] opnd;         // multiplicand or divisor magnitude
  logic [XLEN-1:0] dividend_raw;
  logic            res_neg, rem_neg, is_div, div_zero;

  logic            idle, do_mthi, do_mtlo, start_mul, start_div;
  logic            signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign idle      = (state == IDLE);
  assign do_mthi   = idle && Hilo_en && (Function_opcode == F_MTHI);
  assign do_mtlo   = idle && Hilo_en && (Function_opcode == F_MTLO);
  assign start_mul = idle && Hilo_en &&
                     (Function_opcode == F_MULT || Function_opcode == F_MULTU);
  assign start_div = idle && Hilo_en &&
                     (Function_opcode == F_DIV || Function_opcode == F_DIVU);

  // Signed variants are the even funct codes (mult, div).
  assign signed_op = ~Function_opcode[0];
  assign a_neg     = signed_op & Read_data_1[XLEN-1];
  assign b_neg     = signed_op & Read_data_2[XLEN-1];
  assign a_mag     = a_neg ? -Read_data_1 : Read_data_1;
  assign b_mag     = b_neg ? -Read_data_2 : Read_data_2;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   partial;
  logic            fits;
  logic [XLEN-1:0] rem_sub;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign partial = {rem, acc[XLEN-1]};
  assign fits    = (partial >= {1'b0, opnd});
  // When the divisor fits, the difference is below the divisor, so the low bits suffice.
  assign rem_sub = partial[XLEN-1:0] - opnd;

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder;

  assign product   = res_neg ? -acc : acc;
  assign quotient  = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign remainder = rem_neg ? -rem : rem;

  assign Busy = !idle;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_mul)      state_next = MUL;
        else if (start_div) state_next = DIV;
      end
      MUL, DIV: if (counter == CW'(1)) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale partial result.
  always_ff @(posedge clock) begin
    if (reset) begin
      HI           <= '0;
      LO           <= '0;
      Done         <= 1'b0;
      counter      <= '0;
      acc          <= '0;
      rem          <= '0;
      opnd         <= '0;
      dividend_raw <= '0;
      res_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      is_div       <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      Done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (do_mthi) HI <= Read_data_1;
          if (do_mtlo) LO <= Read_data_1;
          if (start_mul || start_div) begin
            counter      <= CW'(ITER);
            res_neg      <= a_neg ^ b_neg;
            rem_neg      <= a_neg;
            is_div       <= start_div;
            div_zero     <= (Read_data_2 == '0);
            dividend_raw <= Read_data_1;
            rem          <= '0;
            if (start_mul) begin
              opnd <= a_mag;
              acc  <= {{XLEN{1'b0}}, b_mag};
            end else begin
              opnd <= b_mag;
              acc  <= {{XLEN{1'b0}}, a_mag};
            end
          end
        end
        MUL: begin
          counter <= counter - CW'(1);
          acc     <= {mul_sum, acc[XLEN-1:1]};
        end
        DIV: begin
          counter         <= counter - CW'(1);
          rem             <= fits ? rem_sub : partial[XLEN-1:0];
          acc[XLEN-1:0]   <= {acc[XLEN-2:0], fits};
        end
        DONE: begin
          if (!is_div) begin
            HI <= product[2*XLEN-1:XLEN];
            LO <= product[XLEN-1:0];
          end else if (div_zero) begin
            HI <= dividend_raw;
            LO <= '1;
          end else begin
            HI <= remainder;
            LO <= quotient;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases from the test plan plus
// randomized ops compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clock = 1'b0;
  logic        reset;
  logic        Hilo_en;
  logic [5:0]  Function_opcode;
  logic [31:0] Read_data_1, Read_data_2;
  logic [31:0] HI, LO;
  logic        Busy, Done;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv dut (
    .clock          (clock),
    .reset          (reset),
    .Hilo_en        (Hilo_en),
    .Function_opcode(Function_opcode),
    .Read_data_1    (Read_data_1),
    .Read_data_2    (Read_data_2),
    .HI             (HI),
    .LO             (LO),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference result {HI, LO} from the architectural rules, using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (f)
      F_MULT:  res = sa * sb;
      F_MULTU: res = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_busy);
    Hilo_en         = 1'b1;
    Function_opcode = f;
    Read_data_1     = a;
    Read_data_2     = b;
    step();
    Hilo_en         = 1'b0;
    Function_opcode = 6'($urandom);
    Read_data_1     = $urandom;
    Read_data_2     = $urandom;
    checks++;
    if (Busy !== exp_busy) begin
      failures++;
      $display("FAIL issue_busy f=%b: got %b want %b", f, Busy, exp_busy);
    end
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL done_low_after_issue f=%b: got %b want 0", f, Done);
    end
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] a);
    issue(f, a, $urandom, 1'b0);
    if (f == F_MTHI) m_hi = a;
    else             m_lo = a;
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      failures++;
      $display("FAIL move f=%b: got HI=%h LO=%h want HI=%h LO=%h", f, HI, LO, m_hi, m_lo);
    end
  endtask

  // Waits out Busy (bounded), checking HI/LO stay put, then checks the write-back.
  task automatic wait_result(input string name, input logic [63:0] exp, input int already);
    int n = already;
    while (Busy === 1'b1 && n < 40) begin
      checks++;
      if (Done !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
        failures++;
        $display("FAIL %s_hold cyc=%0d: got Done=%b HI=%h LO=%h want Done=0 HI=%h LO=%h",
                 name, n, Done, HI, LO, m_hi, m_lo);
      end
      n++;
      step();
    end
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d want 33", name, n);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    checks++;
    if (Done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: got %b want 1", name, Done);
    end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      failures++;
      $display("FAIL %s_result: got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic run(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp = model(f, a, b);
    issue(f, a, b, 1'b1);
    wait_result(name, exp, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Hilo_en = 1'b0;
    Function_opcode = '0;
    Read_data_1 = '0;
    Read_data_2 = '0;
    step();
    step();
    checks++;
    if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got HI=%h LO=%h Busy=%b Done=%b want all 0", HI, LO, Busy, Done);
    end
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    move_to(F_MTHI, 32'h1234_5678);
    move_to(F_MTLO, 32'hDEAD_BEEF);
  endtask

  task automatic test_mul_div_directed();
    run("mult_neg2x3",  F_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    run("multu_neg2x3", F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    run("div_m7_2",     F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run("divu_100_7",   F_DIVU,  32'd100,       32'd7);
    run("div_by_zero",  F_DIV,   32'h0000_0055, 32'h0000_0000);
    run("divu_by_zero", F_DIVU,  32'h8000_0001, 32'h0000_0000);
    run("div_overflow", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    step();
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got %b want 0", Done);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(F_MULT, 32'd5, 32'd6, 1'b1);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    checks++;
    if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op: got HI=%h LO=%h Busy=%b Done=%b want all 0", HI, LO, Busy, Done);
    end
    run("divu_9_4", F_DIVU, 32'd9, 32'd4);
  endtask

  task automatic test_ignore_while_busy();
    logic [63:0] exp;
    exp = model(F_DIVU, 32'd1000, 32'd7);
    issue(F_DIVU, 32'd1000, 32'd7, 1'b1);
    Hilo_en = 1'b1;
    Function_opcode = F_MTLO;
    Read_data_1 = 32'hAAAA_AAAA;
    Read_data_2 = 32'h0000_0003;
    step();
    checks++;
    if (LO !== m_lo || Busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mtlo_ignored: got LO=%h Busy=%b want LO=%h Busy=1", LO, Busy, m_lo);
    end
    Function_opcode = F_MULT;
    Read_data_1 = $urandom;
    Read_data_2 = $urandom;
    step();
    Hilo_en = 1'b0;
    wait_result("divu_while_busy", exp, 2);
  endtask

  task automatic test_random();
    logic [5:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: f = F_MTHI;
        1: f = F_MTLO;
        2: f = F_MULT;
        3: f = F_MULTU;
        4: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(0, 15)) - 32'd8;
        1: a = 32'h8000_0000;
        2: b = '0;
        default: ;
      endcase
      if (f == F_MTHI || f == F_MTLO) move_to(f, a);
      else run($sformatf("rand%0d", i), f, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul_div_directed();
    test_reset_mid_op();
    test_ignore_while_busy();
    test_random();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers; sits directly downstream of the 32-bit execute stage.
- Consumes the execute stage's operands (rs, rt) and funct code for the HI/LO-class instructions (mult, multu, div, divu, mthi, mtlo).
- Replaces single-cycle combinational mult/div with a 32-iteration datapath and exposes a Busy stall to the PC/decode logic.
- mfhi/mflo read HI/LO directly from this block's outputs.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, iterations per mult/div; must equal XLEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Hilo_en  input  1  instruction in execute is an R-type HI/LO-class op.
- Function_opcode  input  6  instruction[5:0].
- Read_data_1  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- Read_data_2  input  32  rt operand (divisor / multiplier).
- HI  output  32  HI register.
- LO  output  32  LO register.
- Busy  output  1  iteration in progress; CPU must stall.
- Done  output  1  one-cycle pulse when a mult/div result is written.

Behaviour:
- Clock and reset: one clock `clock`; reset `reset` is synchronous, active-high.
- Reset values: HI=0, LO=0, Busy=0, Done=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the iteration; the partial result is discarded.
- Funct decode (valid only when Hilo_en=1):
  - 010001 mthi, 010011 mtlo.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010000/010010 (mfhi/mflo) need no action.
  - Other codes are ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - mthi: HI<=Read_data_1 at the next edge; LO unchanged; no Busy.
  - mtlo: LO<=Read_data_1 at the next edge; HI unchanged; no Busy.
  - mult/multu/div/divu accepted at edge N:
    - Latch operand magnitudes (absolute values when signed), the result-sign flags, and the op type.
    - counter<=32, Busy<=1, next state MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle; partial remainder 33 bits wide.
- Each iteration cycle decrements counter. The iteration with counter=1 moves to DONE.
- DONE, at edge N+33:
  - Apply sign correction, then write HI and LO together.
    - mult/multu: HI=product[63:32], LO=product[31:0].
    - div/divu: LO=quotient, HI=remainder.
  - Busy<=0, Done<=1 for exactly one cycle, return to IDLE.
- Busy timing:
  - High from after edge N through edge N+33, i.e. 33 cycles.
  - Mirrored combinationally: Busy output = (state!=IDLE), so Busy is also high in the DONE cycle.
  - HI/LO hold their old values while Busy=1.
- Signed rules:
  - Product sign = sign(a) xor sign(b).
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(dividend).
  - Negation of the magnitudes is 2's complement.
  - Unsigned ops perform no correction.
- Divide by zero (both div and divu): LO=32'hFFFF_FFFF, HI=Read_data_1 as latched. Still 33 cycles; Busy/Done behave identically.
- Signed overflow, div 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- Any Hilo_en op arriving while Busy=1 is ignored; the CPU guarantees a stall, and the bench checks it is dropped.
- Back-to-back: a new op may be accepted in the first cycle after Done (state IDLE).
- Operands are sampled only at the accept edge; later changes on Read_data_1/2 must not affect the result.

Test Plan:
- Reset, then mthi 0x1234_5678 and mtlo 0xDEAD_BEEF -> HI=0x1234_5678, LO=0xDEAD_BEEF one cycle later; Busy never asserts.
- mult 0xFFFF_FFFE (-2) × 0x0000_0003 -> Busy high 33 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, Done pulse of 1 cycle. multu on the same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- div -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). divu 100 / 7 -> LO=14, HI=2.
- div by zero, 0x0000_0055 / 0 -> LO=0xFFFF_FFFF, HI=0x0000_0055. div 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Start mult 5×6, assert reset at iteration 10 -> next cycle HI=LO=0, Busy=0, Done=0. Then divu 9/4 -> LO=2, HI=1.
- During an active divu, issue mtlo 0xAAAA_AAAA, change Read_data_1/2, and issue a second mult -> all ignored; final result reflects the original operands only.
